// File: rtl/multi_clock_divider_if.sv
// Configuration request port for multi_clock_divider: valid/ready handshake plus error pulse.
// cfg_ch carries one extra code point so out-of-range channel numbers can be expressed.
interface multi_clock_divider_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 28
);
    localparam int unsigned CH_W = $clog2(CHANNELS + 1);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_low;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_low,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_low,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/multi_clock_divider.sv
// N-channel glitch-free clock divider with per-channel enable and period tick.
// New period/low settings are staged in a pending slot and applied only at a period boundary.
module multi_clock_divider #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned DEFAULT_DIV = 50_000_000
) (
    input  logic                 clk_50M,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  en,
    input  logic                 sync,
    multi_clock_divider_if.slave cfg,
    output logic [CHANNELS-1:0]  clk_out,
    output logic [CHANNELS-1:0]  tick
);
    localparam int unsigned      CH_W   = $clog2(CHANNELS + 1);
    localparam logic [CNT_W-1:0] DefPer = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DefLow = CNT_W'(DEFAULT_DIV / 2);

    logic [CNT_W-1:0] cnt_q  [CHANNELS];
    logic [CNT_W-1:0] cnt_d  [CHANNELS];
    logic [CNT_W-1:0] per_q  [CHANNELS];
    logic [CNT_W-1:0] per_d  [CHANNELS];
    logic [CNT_W-1:0] low_q  [CHANNELS];
    logic [CNT_W-1:0] low_d  [CHANNELS];
    logic [CNT_W-1:0] pdiv_q [CHANNELS];
    logic [CNT_W-1:0] pdiv_d [CHANNELS];
    logic [CNT_W-1:0] plow_q [CHANNELS];
    logic [CNT_W-1:0] plow_d [CHANNELS];

    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] wrap, store_sel;
    logic [2**CH_W-1:0]  pend_ext;
    logic                ch_ok, legal, accept, err_q;

    // Handshake decode; out-of-range channels index a zero bit so they are always ready.
    always_comb begin
        pend_ext                 = '0;
        pend_ext[CHANNELS-1:0]   = pend_q;
        ch_ok                    = (32'(cfg.cfg_ch) < CHANNELS);
        legal                    = ch_ok && (cfg.cfg_div >= CNT_W'(2)) && (cfg.cfg_low != '0) &&
                                   (cfg.cfg_low < cfg.cfg_div);
        cfg.cfg_ready            = ~pend_ext[cfg.cfg_ch];
        accept                   = cfg.cfg_valid & cfg.cfg_ready;
    end

    always_comb begin
        wrap      = '0;
        store_sel = '0;
        pend_d    = pend_q;
        clk_out_d = '0;
        tick_d    = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            cnt_d[i]  = cnt_q[i];
            per_d[i]  = per_q[i];
            low_d[i]  = low_q[i];
            pdiv_d[i] = pdiv_q[i];
            plow_d[i] = plow_q[i];

            wrap[i]      = en[i] && (cnt_q[i] == per_q[i] - CNT_W'(1));
            store_sel[i] = accept && legal && (cfg.cfg_ch == CH_W'(i));

            if (sync || !en[i] || wrap[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // A pending slot is never filled in the same cycle it is applied (ready is low).
            if (pend_q[i] && (sync || !en[i] || wrap[i])) begin
                per_d[i]  = pdiv_q[i];
                low_d[i]  = plow_q[i];
                pend_d[i] = 1'b0;
            end
            if (store_sel[i]) begin
                pend_d[i] = 1'b1;
                pdiv_d[i] = cfg.cfg_div;
                plow_d[i] = cfg.cfg_low;
            end

            clk_out_d[i] = en[i] && !sync && (cnt_q[i] >= low_q[i]);
            tick_d[i]    = wrap[i] && !sync;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i]  <= '0;
                per_q[i]  <= DefPer;
                low_q[i]  <= DefLow;
                pdiv_q[i] <= '0;
                plow_q[i] <= '0;
            end
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                cnt_q[i]  <= cnt_d[i];
                per_q[i]  <= per_d[i];
                low_q[i]  <= low_d[i];
                pdiv_q[i] <= pdiv_d[i];
                plow_q[i] <= plow_d[i];
            end
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            err_q     <= accept & ~legal;
        end
    end

    assign clk_out     = clk_out_q;
    assign tick        = tick_q;
    assign cfg.cfg_err = err_q;
endmodule
